// File: rtl/path_reader_pkg.sv
// Shared constants and state encoding for the path readout block.
package path_reader_pkg;

    localparam int PATH_MAX = 37;
    localparam int DATA_W   = 32;

    // Terminator word stored after the last valid node of a path.
    localparam logic signed [DATA_W-1:0] SENTINEL = '1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        HOLD,
        FIN
    } state_t;

endpackage

// File: rtl/path_reader_if.sv
// Path memory port plus the outgoing node stream handshake.
interface path_reader_if
    import path_reader_pkg::*;
#(
    parameter int DATA_W = path_reader_pkg::DATA_W
);

    logic              wen_path;
    logic [31:0]       path_add;
    logic [DATA_W-1:0] path_input;
    logic [DATA_W-1:0] path_output;
    logic [DATA_W-1:0] node_out;
    logic              node_valid;
    logic              node_ready;
    logic              node_last;

    modport master (
        output wen_path, path_add, path_input, node_out, node_valid, node_last,
        input  path_output, node_ready
    );

    modport slave (
        input  wen_path, path_add, path_input, node_out, node_valid, node_last,
        output path_output, node_ready
    );

endinterface

// File: rtl/path_reader.sv
// Reads a sentinel-terminated path out of memory and streams its nodes.
// One word of lookahead is kept so node_last is already correct when a
// node is first presented.
module path_reader
    import path_reader_pkg::*;
#(
    parameter int PATH_MAX = path_reader_pkg::PATH_MAX,
    parameter int DATA_W   = path_reader_pkg::DATA_W
) (
    input  logic                 clk_50,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [5:0]           node_count,
    path_reader_if.master        bus
);

    state_t            state, state_nxt;
    logic [31:0]       path_add_q;
    logic [DATA_W-1:0] node_q;      // node currently held for output
    logic [DATA_W-1:0] pend_q;      // lookahead word read behind node_q
    logic              last_q;
    logic              have_q;      // node_q holds a real node
    logic              pend_last_q; // pend_q came from index PATH_MAX
    logic              overrun_q;
    logic [5:0]        cnt_q;
    logic              node_valid;
    logic              is_sent;
    logic              at_max;

    assign is_sent = (bus.path_output == DATA_W'(SENTINEL));
    assign at_max  = (path_add_q == 32'(PATH_MAX));

    assign bus.wen_path   = 1'b0;
    assign bus.path_input = '0;
    assign bus.path_add   = path_add_q;
    assign bus.node_out   = node_q;
    assign bus.node_last  = last_q;
    assign bus.node_valid = node_valid;
    assign overrun        = overrun_q;
    assign node_count     = cnt_q;

    // State register
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        done       = (state == FIN);
        node_valid = (state == HOLD);
        case (state)
            IDLE: if (start) state_nxt = ADDR;
            ADDR: state_nxt = WAIT;
            WAIT: begin
                if (is_sent)                state_nxt = have_q ? HOLD : FIN;
                else if (have_q || at_max)  state_nxt = HOLD;
                else                        state_nxt = ADDR;
            end
            HOLD: begin
                if (bus.node_ready) begin
                    if (last_q)           state_nxt = FIN;
                    else if (pend_last_q) state_nxt = HOLD;
                    else                  state_nxt = ADDR;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address, holding registers, count and overrun flag
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            path_add_q  <= '0;
            node_q      <= '0;
            pend_q      <= '0;
            last_q      <= 1'b0;
            have_q      <= 1'b0;
            pend_last_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        path_add_q  <= '0;
                        last_q      <= 1'b0;
                        have_q      <= 1'b0;
                        pend_last_q <= 1'b0;
                        overrun_q   <= 1'b0;
                        cnt_q       <= '0;
                    end
                end
                WAIT: begin
                    if (is_sent) begin
                        if (have_q) last_q <= 1'b1;
                    end else if (!have_q) begin
                        // First word only primes the holding register.
                        node_q <= bus.path_output;
                        have_q <= 1'b1;
                        if (at_max) begin
                            last_q    <= 1'b1;
                            overrun_q <= 1'b1;
                        end else begin
                            path_add_q <= path_add_q + 32'd1;
                        end
                    end else begin
                        pend_q <= bus.path_output;
                        if (at_max) begin
                            pend_last_q <= 1'b1;
                            overrun_q   <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.node_ready) begin
                        cnt_q <= cnt_q + 6'd1;
                        if (!last_q) begin
                            node_q <= pend_q;
                            if (pend_last_q) begin
                                // Table end without sentinel: final entry closes the path.
                                last_q      <= 1'b1;
                                pend_last_q <= 1'b0;
                            end else begin
                                path_add_q <= path_add_q + 32'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
